// File: rtl/dct_trace_packer_if.sv
// Handshake bundle for dct_trace_packer: narrow trace items in, tagged packed words out.
interface dct_trace_packer_if #(
  parameter int ITEM_W  = 6,
  parameter int ITEMS   = 5,
  parameter int COUNT_W = 4
);
  logic [ITEM_W-1:0]       item_data;
  logic                    item_valid;
  logic                    item_ready;
  logic [ITEM_W*ITEMS-1:0] dct_buffer;
  logic [COUNT_W-1:0]      dct_count;
  logic                    dct_valid;
  logic                    dct_ready;

  // master: trace source plus word consumer; slave: the packer itself
  modport master (
    output item_data, item_valid, dct_ready,
    input  item_ready, dct_buffer, dct_count, dct_valid
  );

  modport slave (
    input  item_data, item_valid, dct_ready,
    output item_ready, dct_buffer, dct_count, dct_valid
  );
endinterface

// File: rtl/dct_trace_packer.sv
// Packs ITEM_W-bit trace items into count-tagged words, queues them in a FWFT FIFO and
// flushes/drains on test_ending. Define DCT_TRACE_PACKER_LOSSY_EN to drop instead of stall.
module dct_trace_packer #(
  parameter int ITEM_W     = 6,
  parameter int ITEMS      = 5,
  parameter int COUNT_W    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  dct_trace_packer_if.slave    bus,
  input  logic                 test_ending,
  output logic                 test_has_ended
`ifdef DCT_TRACE_PACKER_LOSSY_EN
  ,
  output logic [15:0]          drop_count
`endif
);
  localparam int DCT_W  = ITEM_W * ITEMS;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [COUNT_W-1:0] ITEMS_C = COUNT_W'(ITEMS);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t state_q, state_d;

  logic               te_q;
  logic               te_rise;
  logic [DCT_W-1:0]   pack_q, pack_d;
  logic [COUNT_W-1:0] pack_cnt_q, pack_cnt_d;
  logic               word_full;
  logic               item_ready_c;
  logic               accept;
  logic               push;
  logic               pop;
  logic               can_push;

  logic [DCT_W-1:0]   mem_data [FIFO_DEPTH];
  logic [COUNT_W-1:0] mem_cnt  [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [FCNT_W-1:0]  fifo_count;
  logic               fifo_full;
  logic               head_valid;

  assign te_rise    = test_ending & ~te_q;
  assign word_full  = (pack_cnt_q == ITEMS_C);
  assign fifo_full  = (fifo_count == FCNT_W'(FIFO_DEPTH));
  assign head_valid = (fifo_count != '0);
  assign pop        = head_valid & bus.dct_ready;
  // a pop in the same cycle frees the slot the push lands in
  assign can_push   = ~fifo_full | pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      te_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      te_q    <= test_ending;
    end
  end

  always_comb begin
    state_d      = state_q;
    push         = 1'b0;
    item_ready_c = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        push = word_full & can_push;
`ifdef DCT_TRACE_PACKER_LOSSY_EN
        item_ready_c = 1'b1;
`else
        item_ready_c = ~word_full | push;
`endif
        if (te_rise) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (pack_cnt_q == '0) begin
          state_d = ST_DRAIN;
        end else if (can_push) begin
          push    = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_count == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // in lossy mode item_ready stays high, so a full word that cannot move gates acceptance here
  assign accept         = bus.item_valid & item_ready_c & (~word_full | push);
  assign bus.item_ready = item_ready_c;

  always_comb begin
    pack_d     = pack_q;
    pack_cnt_d = pack_cnt_q;
    if (push) begin
      pack_d     = '0;
      pack_cnt_d = '0;
    end
    if (accept) begin
      for (int unsigned i = 0; i < ITEMS; i++) begin
        if (32'(pack_cnt_d) == i) pack_d[i*ITEM_W +: ITEM_W] = bus.item_data;
      end
      pack_cnt_d = pack_cnt_d + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pack_q     <= '0;
      pack_cnt_q <= '0;
    end else begin
      pack_q     <= pack_d;
      pack_cnt_q <= pack_cnt_d;
    end
  end

  // storage needs no reset: the head is masked to zero whenever the FIFO is empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= pack_q;
      mem_cnt[wr_ptr]  <= pack_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
        2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign bus.dct_valid  = head_valid;
  assign bus.dct_buffer = head_valid ? mem_data[rd_ptr] : '0;
  assign bus.dct_count  = head_valid ? mem_cnt[rd_ptr]  : '0;
  assign test_has_ended = (state_q == ST_DONE);

`ifdef DCT_TRACE_PACKER_LOSSY_EN
  logic drop;
  assign drop = bus.item_valid & item_ready_c & word_full & ~push;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop && drop_count != '1) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dct_trace_packer.sv
// Self-checking bench for dct_trace_packer: random item streams against a queue-based packing model.
module tb_dct_trace_packer;
  localparam int ITEM_W     = 6;
  localparam int ITEMS      = 5;
  localparam int COUNT_W    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int DCT_W      = ITEM_W * ITEMS;
  localparam int TMO        = 200;
`ifdef DCT_TRACE_PACKER_LOSSY_EN
  localparam bit LOSSY = 1'b1;
`else
  localparam bit LOSSY = 1'b0;
`endif

  typedef struct {
    logic [DCT_W-1:0]   data;
    logic [COUNT_W-1:0] cnt;
  } word_t;

  logic clk = 1'b0;
  logic reset;
  logic test_ending;
  logic test_has_ended;
`ifdef DCT_TRACE_PACKER_LOSSY_EN
  logic [15:0] drop_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  word_t             got_q[$];
  logic [ITEM_W-1:0] sent_q[$];

  dct_trace_packer_if #(.ITEM_W(ITEM_W), .ITEMS(ITEMS), .COUNT_W(COUNT_W)) bus ();

  dct_trace_packer #(
    .ITEM_W    (ITEM_W),
    .ITEMS     (ITEMS),
    .COUNT_W   (COUNT_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .test_ending   (test_ending),
    .test_has_ended(test_has_ended)
`ifdef DCT_TRACE_PACKER_LOSSY_EN
    ,
    .drop_count    (drop_count)
`endif
  );

  always #5 clk = ~clk;

  // record every word the consumer takes
  always @(negedge clk) begin
    if (!reset && bus.dct_valid && bus.dct_ready)
      got_q.push_back('{bus.dct_buffer, bus.dct_count});
  end

  // reference: word built from n consecutive sent items, item 0 in the LSBs
  function automatic word_t model_word(input int unsigned start, input int unsigned n);
    word_t w;
    w.data = '0;
    w.cnt  = COUNT_W'(n);
    for (int unsigned i = 0; i < n; i++)
      w.data = w.data | (DCT_W'(sent_q[start+i]) << (ITEM_W * i));
    return w;
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    got_q.delete();
    sent_q.delete();
  endtask

  task automatic send_item(input logic [ITEM_W-1:0] d, output int waits, output bit ok);
    waits = 0;
    bus.item_valid = 1'b1;
    bus.item_data  = d;
    @(negedge clk);
    while (!bus.item_ready && waits < TMO) begin
      waits++;
      @(negedge clk);
    end
    ok = bus.item_ready;
    @(posedge clk);
    #1;
    bus.item_valid = 1'b0;
    if (ok) sent_q.push_back(d);
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (bus.item_ready !== 1'b1) begin n_fail++; $display("FAIL reset_item_ready: got %b exp 1", bus.item_ready); end
    n_checks++;
    if (bus.dct_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dct_valid: got %b exp 0", bus.dct_valid); end
    n_checks++;
    if (bus.dct_buffer !== '0) begin n_fail++; $display("FAIL reset_dct_buffer: got %h exp 0", bus.dct_buffer); end
    n_checks++;
    if (bus.dct_count !== '0) begin n_fail++; $display("FAIL reset_dct_count: got %0d exp 0", bus.dct_count); end
    n_checks++;
    if (test_has_ended !== 1'b0) begin n_fail++; $display("FAIL reset_has_ended: got %b exp 0", test_has_ended); end
  endtask

  task automatic test_basic_word();
    int w;
    bit ok, all_ok;
    word_t e;
    got_q.delete();
    sent_q.delete();
    all_ok = 1'b1;
    bus.dct_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      send_item(ITEM_W'(i), w, ok);
      all_ok &= ok;
    end
    n_checks++;
    if (all_ok !== 1'b1 || bus.dct_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_pre_push: accepted=%b dct_valid=%b exp 1/0", all_ok, bus.dct_valid);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.dct_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_latency: got %b exp 1", bus.dct_valid); end
    n_checks++;
    if (bus.dct_buffer !== 30'h05103081) begin n_fail++; $display("FAIL basic_buffer: got %h exp 05103081", bus.dct_buffer); end
    n_checks++;
    if (bus.dct_count !== 4'd5) begin n_fail++; $display("FAIL basic_count: got %0d exp 5", bus.dct_count); end
    repeat (3) @(posedge clk);
    #1;
    e = model_word(0, 5);
    n_checks++;
    if (got_q.size() != 1 || got_q[0].data !== e.data || got_q[0].cnt !== e.cnt || bus.dct_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_popped: words=%0d valid=%b exp 1 word %h/%0d", got_q.size(), bus.dct_valid, e.data, e.cnt);
    end
  endtask

  task automatic test_full_throughput();
    int w, total_wait;
    bit ok;
    word_t e, a;
    got_q.delete();
    sent_q.delete();
    total_wait = 0;
    bus.dct_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      send_item(ITEM_W'($urandom), w, ok);
      total_wait += w;
    end
    n_checks++;
    if (total_wait != 0) begin n_fail++; $display("FAIL tput_ready_stall: stall cycles %0d exp 0", total_wait); end
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (got_q.size() != 10) begin n_fail++; $display("FAIL tput_word_count: got %0d exp 10", got_q.size()); end
    for (int k = 0; k < 10; k++) begin
      e = model_word(k * ITEMS, ITEMS);
      a = (k < got_q.size()) ? got_q[k] : '{'0, '0};
      n_checks++;
      if (a.data !== e.data || a.cnt !== e.cnt) begin
        n_fail++; $display("FAIL tput_word%0d: got %h/%0d exp %h/%0d", k, a.data, a.cnt, e.data, e.cnt);
      end
    end
  endtask

  task automatic test_backpressure();
    int w, total_wait;
    bit ok, all_ok;
    word_t e, a;
    got_q.delete();
    sent_q.delete();
    all_ok = 1'b1;
    bus.dct_ready = 1'b0;
    for (int i = 0; i < 25; i++) begin
      send_item(ITEM_W'($urandom), w, ok);
      all_ok &= ok;
    end
    n_checks++;
    if (all_ok !== 1'b1) begin n_fail++; $display("FAIL bp_accept25: got %b exp 1", all_ok); end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.item_ready !== LOSSY) begin n_fail++; $display("FAIL bp_item_ready: got %b exp %b", bus.item_ready, LOSSY); end
    e = model_word(0, ITEMS);
    n_checks++;
    if (bus.dct_valid !== 1'b1 || bus.dct_buffer !== e.data) begin
      n_fail++; $display("FAIL bp_head: valid=%b buf=%h exp 1/%h", bus.dct_valid, bus.dct_buffer, e.data);
    end
    bus.dct_ready = 1'b1;
    total_wait = 0;
    for (int i = 0; i < 10; i++) begin
      send_item(ITEM_W'($urandom), w, ok);
      total_wait += w;
    end
    n_checks++;
    if (total_wait != 0) begin n_fail++; $display("FAIL bp_resume_stall: stall cycles %0d exp 0", total_wait); end
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (got_q.size() != 7) begin n_fail++; $display("FAIL bp_word_count: got %0d exp 7", got_q.size()); end
    for (int k = 0; k < 7; k++) begin
      e = model_word(k * ITEMS, ITEMS);
      a = (k < got_q.size()) ? got_q[k] : '{'0, '0};
      n_checks++;
      if (a.data !== e.data || a.cnt !== e.cnt) begin
        n_fail++; $display("FAIL bp_word%0d: got %h/%0d exp %h/%0d", k, a.data, a.cnt, e.data, e.cnt);
      end
    end
  endtask

  task automatic test_flush();
    int w, cyc;
    bit ok;
    word_t e, a;
    got_q.delete();
    sent_q.delete();
    bus.dct_ready = 1'b0;
    send_item(6'h3F, w, ok);
    send_item(6'h01, w, ok);
    test_ending = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.item_ready !== 1'b0) begin n_fail++; $display("FAIL flush_item_ready: got %b exp 0", bus.item_ready); end
    repeat (4) @(posedge clk);
    #1;
    e = model_word(0, 2);
    n_checks++;
    if (bus.dct_valid !== 1'b1 || bus.dct_buffer !== e.data || bus.dct_buffer !== 30'h0000007F) begin
      n_fail++; $display("FAIL flush_buffer: valid=%b buf=%h exp 1/0000007f", bus.dct_valid, bus.dct_buffer);
    end
    n_checks++;
    if (bus.dct_count !== 4'd2) begin n_fail++; $display("FAIL flush_count: got %0d exp 2", bus.dct_count); end
    n_checks++;
    if (test_has_ended !== 1'b0 || bus.item_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_hold: has_ended=%b item_ready=%b exp 0/0", test_has_ended, bus.item_ready);
    end
    bus.dct_ready = 1'b1;
    cyc = 0;
    while (!test_has_ended && cyc < TMO) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (test_has_ended !== 1'b1) begin n_fail++; $display("FAIL flush_has_ended: got %b exp 1 (timeout)", test_has_ended); end
    a = (got_q.size() > 0) ? got_q[0] : '{'0, '0};
    n_checks++;
    if (got_q.size() != 1 || a.data !== e.data || a.cnt !== e.cnt) begin
      n_fail++; $display("FAIL flush_popped: words=%0d got %h/%0d exp 1 word %h/%0d", got_q.size(), a.data, a.cnt, e.data, e.cnt);
    end
    test_ending = 1'b0;
    repeat (3) @(posedge clk);
    test_ending = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (test_has_ended !== 1'b1 || bus.item_ready !== 1'b0 || bus.dct_valid !== 1'b0) begin
      n_fail++; $display("FAIL done_sticky: has_ended=%b item_ready=%b valid=%b exp 1/0/0", test_has_ended, bus.item_ready, bus.dct_valid);
    end
    test_ending = 1'b0;
  endtask

  task automatic test_reset_mid();
    int w;
    bit ok;
    word_t e, a;
    apply_reset();
    bus.dct_ready = 1'b0;
    for (int i = 0; i < 13; i++) send_item(ITEM_W'($urandom), w, ok);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.dct_valid !== 1'b1 || bus.item_ready !== 1'b1) begin
      n_fail++; $display("FAIL rmid_setup: valid=%b item_ready=%b exp 1/1", bus.dct_valid, bus.item_ready);
    end
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.dct_valid !== 1'b0 || bus.dct_count !== '0 || bus.dct_buffer !== '0) begin
      n_fail++; $display("FAIL rmid_async_outputs: valid=%b count=%0d buf=%h exp 0/0/0", bus.dct_valid, bus.dct_count, bus.dct_buffer);
    end
    n_checks++;
    if (test_has_ended !== 1'b0 || bus.item_ready !== 1'b1) begin
      n_fail++; $display("FAIL rmid_async_ctrl: has_ended=%b item_ready=%b exp 0/1", test_has_ended, bus.item_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    got_q.delete();
    sent_q.delete();
    bus.dct_ready = 1'b1;
    send_item(6'h2A, w, ok);
    for (int i = 0; i < 4; i++) send_item(ITEM_W'($urandom), w, ok);
    repeat (5) @(posedge clk);
    #1;
    e = model_word(0, ITEMS);
    a = (got_q.size() > 0) ? got_q[0] : '{'0, '0};
    n_checks++;
    if (got_q.size() != 1 || a.data[ITEM_W-1:0] !== 6'h2A) begin
      n_fail++; $display("FAIL rmid_slot0: words=%0d slot0=%h exp 1 word slot0 2a", got_q.size(), a.data[ITEM_W-1:0]);
    end
    n_checks++;
    if (a.data !== e.data || a.cnt !== e.cnt) begin
      n_fail++; $display("FAIL rmid_word: got %h/%0d exp %h/%0d", a.data, a.cnt, e.data, e.cnt);
    end
  endtask

`ifdef DCT_TRACE_PACKER_LOSSY_EN
  task automatic test_lossy();
    int w, total_wait;
    bit ok;
    word_t e, a;
    apply_reset();
    bus.dct_ready = 1'b0;
    total_wait = 0;
    for (int i = 0; i < 30; i++) begin
      send_item(ITEM_W'($urandom), w, ok);
      total_wait += w;
    end
    n_checks++;
    if (total_wait != 0) begin n_fail++; $display("FAIL lossy_ready: stall cycles %0d exp 0", total_wait); end
    n_checks++;
    if (drop_count !== 16'd5) begin n_fail++; $display("FAIL lossy_drop_count: got %0d exp 5", drop_count); end
    bus.dct_ready = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    n_checks++;
    if (got_q.size() != 5) begin n_fail++; $display("FAIL lossy_word_count: got %0d exp 5", got_q.size()); end
    for (int k = 0; k < 5; k++) begin
      e = model_word(k * ITEMS, ITEMS);
      a = (k < got_q.size()) ? got_q[k] : '{'0, '0};
      n_checks++;
      if (a.data !== e.data || a.cnt !== e.cnt) begin
        n_fail++; $display("FAIL lossy_word%0d: got %h/%0d exp %h/%0d", k, a.data, a.cnt, e.data, e.cnt);
      end
    end
  endtask
`endif

  initial begin
    reset          = 1'b1;
    test_ending    = 1'b0;
    bus.item_valid = 1'b0;
    bus.item_data  = '0;
    bus.dct_ready  = 1'b0;
    test_reset();
    test_basic_word();
    test_full_throughput();
    test_backpressure();
    test_flush();
    test_reset_mid();
`ifdef DCT_TRACE_PACKER_LOSSY_EN
    test_lossy();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dct_trace_packer.md
Name: dct_trace_packer

Overview:
- Parametrised successor to the CPU OCI debug-capture-trace (DCT) test-bench observer.
- Packs narrow trace items from the OCI into DCT_W-wide buffer words, each tagged with a valid-item count.
- Queues words in a small FIFO and presents them on a valid/ready port.
- On test_ending: flushes the partial word, drains the FIFO, then raises sticky test_has_ended.

Parameters:
ITEM_W, 6, width of one trace item in bits
ITEMS, 5, items per buffer word; DCT_W = ITEM_W*ITEMS (30 by default)
COUNT_W, 4, width of dct_count; must satisfy 2**COUNT_W > ITEMS
FIFO_DEPTH, 4, output FIFO entries; power of two, minimum 2

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-high reset
item_data  in  ITEM_W  trace item
item_valid  in  1  item present
item_ready  out  1  item accepted when item_valid & item_ready at a rising clk edge
test_ending  in  1  level; rising edge starts flush
dct_buffer  out  ITEM_W*ITEMS  packed word; item 0 in LSBs, unused slots zero
dct_count  out  COUNT_W  number of valid items in dct_buffer, range 1..ITEMS
dct_valid  out  1  FIFO head valid
dct_ready  in  1  consumer takes head when dct_valid & dct_ready
test_has_ended  out  1  sticky; flush and drain complete

Behaviour:
- Reset (asynchronous, active-high):
  - State RUN; pack_cnt=0; pack register cleared; FIFO empty.
  - Outputs: item_ready=1, dct_valid=0, dct_buffer=0, dct_count=0, test_has_ended=0.
  - Reset mid-operation discards all pending data.
- Packing:
  - An accepted item is written to slot pack_cnt (bits [pack_cnt*ITEM_W +: ITEM_W]); pack_cnt increments.
  - When pack_cnt==ITEMS, the word is "full". It is pushed to the FIFO at the next edge where the FIFO is not full, or is being popped in that same cycle. The push carries count ITEMS.
  - Push clears the pack register and sets pack_cnt=0.
- item_ready:
  - Equals (state==RUN) & (pack_cnt<ITEMS | push_this_cycle).
  - Simultaneous push and accept: the new item lands in slot 0 and pack_cnt becomes 1. No bubble at full throughput.
- FIFO:
  - First-word-fall-through; dct_valid = (fifo_count!=0).
  - dct_buffer/dct_count show the head entry, and show 0 when empty.
  - Simultaneous push and pop while full is legal; occupancy is unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Latency: the 5th item accepted at edge N is pushed at edge N+1, and dct_valid is visible after edge N+1 when the FIFO was empty.
- State machine:
  - RUN -> FLUSH on a rising edge of test_ending (registered edge detect). item_ready=0 from the cycle after the edge is registered. An item accepted in the edge cycle is kept.
  - FLUSH: if pack_cnt>0, push the partial word with count=pack_cnt as soon as the FIFO accepts it. Go to DRAIN after the push, or immediately if pack_cnt==0.
  - DRAIN -> DONE when fifo_count==0.
  - DONE: test_has_ended=1 until reset; item_ready=0; further test_ending edges ignored.
- The consumer may hold dct_ready low indefinitely. There is no timeout, and no data is lost.
- test_ending held high from reset release counts as a rising edge one cycle after release.

Optional Feature:
- Macro DCT_TRACE_PACKER_LOSSY_EN.
- Defined:
  - item_ready=1 whenever state==RUN.
  - An item arriving while the word is full and the FIFO cannot accept is dropped.
  - Extra output port drop_count (16 bits, reset 0, saturating at 0xFFFF) increments once per dropped item.
  - The pack register is unchanged by a drop.
- Undefined:
  - Backpressure behaviour as above; no drop_count port.

Test Plan:
- Items 0x01..0x05 back-to-back, dct_ready=1 -> one word dct_buffer=0x05103081, dct_count=5, dct_valid high 1 cycle after push edge.
- Items 0x3F,0x01 then test_ending rising -> dct_buffer=0x0000007F, dct_count=2; test_has_ended=1 after pop; item_ready=0 from FLUSH onward.
- dct_ready=0, stream 25 items (FIFO_DEPTH=4) -> 4 words queued, 5th word full, item_ready=0. Release dct_ready -> 5 words in order, no loss, continuous item flow then resumes.
- Full throughput with dct_ready=1: 50 items with item_valid constant -> item_ready never drops, 10 words with count 5.
- Reset asserted with 2 queued words and pack_cnt=3 -> dct_valid=0, dct_count=0, test_has_ended=0 immediately, asynchronously. Post-reset item 0x2A -> first word starts at slot 0.
- With DCT_TRACE_PACKER_LOSSY_EN, dct_ready=0, 30 items -> 25 retained, drop_count=5, item_ready stays 1.
